// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: load-type codes (also used by the decoder),
// load FSM state encoding and small load-classification helpers.
package mips_mem_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } ld_state_e;

  // Undefined encodings 5-7 behave as LW.
  function automatic logic [2:0] norm_type(input logic [2:0] t);
    return (t > LD_LBU) ? LD_LW : t;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    logic [2:0] nt;
    nt = norm_type(t);
    return ((nt == LD_LH || nt == LD_LHU) && off[0]) || (nt == LD_LW && off != 2'b00);
  endfunction

  // Offset bits a load type cannot use are forced to zero.
  function automatic logic [1:0] align_off(input logic [2:0] t, input logic [1:0] off);
    logic [2:0] nt;
    nt = norm_type(t);
    if (nt == LD_LW) return 2'b00;
    if (nt == LD_LH || nt == LD_LHU) return {off[1], 1'b0};
    return off;
  endfunction

endpackage

// File: rtl/mod_load_ext.sv
// Combinational byte/halfword extraction and sign/zero extension of a read word.
// Little-endian lanes; also reused by the forwarding path.
module mod_load_ext
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata[{off, 3'b000} +: 8];
  assign half_val = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (ld_type)
      LD_LH:   data = {{16{half_val[15]}}, half_val};
      LD_LHU:  data = {16'h0000, half_val};
      LD_LB:   data = {{24{byte_val[7]}}, byte_val};
      LD_LBU:  data = {24'h000000, byte_val};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mod_load_align.sv
// MEM-stage load unit: word-aligned read issue, wait-state tolerant response,
// extract/extend. Optional AdEL trap on misaligned loads via MOD_LOAD_ALIGN_TRAP_EN.
module mod_load_align
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_req,
  input  logic [2:0]    ld_type,
  input  logic [AW-1:0] addr,
  input  logic          flush,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          ld_busy,
  output logic [DW-1:0] ld_data,
  output logic          ld_valid,
  output logic          ld_misalign
);

  ld_state_e     state_reg, state_next;
  logic [2:0]    type_reg;
  logic [1:0]    off_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;
  logic [DW-1:0] ext_data;
  logic          trap_hit;
  logic          accept;

  mod_load_ext u_ext (
    .rdata   (mem_rdata),
    .off     (off_reg),
    .ld_type (type_reg),
    .data    (ext_data)
  );

`ifdef MOD_LOAD_ALIGN_TRAP_EN
  logic misalign_reg;

  assign trap_hit = is_misaligned(ld_type, addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_reg <= 1'b0;
    else        misalign_reg <= (state_reg == ST_IDLE) && ld_req && !flush && trap_hit;
  end

  assign ld_misalign = misalign_reg;
`else
  assign trap_hit    = 1'b0;
  assign ld_misalign = 1'b0;
`endif

  assign accept = (state_reg == ST_IDLE) && ld_req && !flush && !trap_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      type_reg  <= 3'd0;
      off_reg   <= 2'd0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        type_reg <= norm_type(ld_type);
        off_reg  <= align_off(ld_type, addr[1:0]);
        addr_reg <= {addr[AW-1:2], 2'b00};
      end
      if (state_reg == ST_WAIT && mem_rvalid && !flush) data_reg <= ext_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = flush ? ST_DRAIN : ST_WAIT;
      // A flush coinciding with the response drops it and frees the unit at once.
      ST_WAIT: begin
        if (flush)           state_next = mem_rvalid ? ST_IDLE : ST_DRAIN;
        else if (mem_rvalid) state_next = ST_RESP;
      end
      ST_RESP:  state_next = ST_IDLE;
      ST_DRAIN: if (mem_rvalid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign mem_rd_en = (state_reg == ST_ISSUE);
  assign ld_busy   = (state_reg != ST_IDLE);
  assign ld_valid  = (state_reg == ST_RESP) && !flush;
  assign mem_addr  = addr_reg;
  assign ld_data   = data_reg;

endmodule

// File: tb/tb_mod_load_align.sv
// Randomized self-checking bench for mod_load_align against an arithmetic load model.
// Build with or without MOD_LOAD_ALIGN_TRAP_EN; expectations follow the same macro.
module tb_mod_load_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic [2:0]  ld_type = 3'd0;
  logic [31:0] addr = 32'd0;
  logic        flush = 1'b0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic        ld_busy;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ld_misalign;

  int vectors = 0;
  int miscompares = 0;
  int valid_seen = 0, rd_seen = 0, exp_valid = 0, exp_rd = 0;

`ifdef MOD_LOAD_ALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mod_load_align #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_type(ld_type), .addr(addr),
    .flush(flush), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .ld_busy(ld_busy), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_misalign(ld_misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ld_valid)  valid_seen++;
    if (mem_rd_en) rd_seen++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int mtype(input logic [2:0] t);
    return (t > 3'd4) ? 0 : int'(t);
  endfunction

  function automatic bit model_misaligned(input logic [2:0] t, input logic [31:0] a);
    int k = mtype(t);
    int off = int'(a % 4);
    return ((k == 1 || k == 2) && (off % 2 == 1)) || (k == 0 && off != 0);
  endfunction

  // Arithmetic reference: shift the word right by the lane, mask, extend.
  function automatic logic [31:0] model_data(input logic [2:0] t, input logic [31:0] a,
                                              input logic [31:0] rd);
    int k = mtype(t);
    int off = int'(a % 4);
    logic [31:0] v;
    if (k == 0) return rd;
    if (k == 1 || k == 2) begin
      v = (rd >> ((off / 2) * 16)) & 32'h0000FFFF;
      if (k == 1 && v >= 32'd32768) v = v | 32'hFFFF0000;
      return v;
    end
    v = (rd >> (off * 8)) & 32'h000000FF;
    if (k == 3 && v >= 32'd128) v = v | 32'hFFFFFF00;
    return v;
  endfunction

  // fmode: 0 normal, 1 flush in WAIT then late response, 2 flush with response.
  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd,
                         input int waits, input int fmode);
    logic [31:0] aligned;
    int busy_cycles;
    aligned = a & 32'hFFFFFFFC;
    busy_cycles = 0;
    @(negedge clk);
    ld_req = 1'b1; ld_type = t; addr = a;
    @(negedge clk);
    ld_req = 1'b0;
    if (TRAP && model_misaligned(t, a)) begin
      check("trap_misalign", {31'd0, ld_misalign}, 32'd1);
      check("trap_busy", {31'd0, ld_busy}, 32'd0);
      check("trap_rd_en", {31'd0, mem_rd_en}, 32'd0);
      @(negedge clk);
      check("trap_misalign_pulse", {31'd0, ld_misalign}, 32'd0);
      $display("load type=%0d addr=%h trapped", t, a);
      return;
    end
    exp_rd++;
    check("issue_rd_en", {31'd0, mem_rd_en}, 32'd1);
    check("issue_addr", mem_addr, aligned);
    check("misalign_low", {31'd0, ld_misalign}, 32'd0);
    if (ld_busy) busy_cycles++;
    @(negedge clk);
    if (fmode == 1) begin
      flush = 1'b1;
      if (ld_busy) busy_cycles++;
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
        check("drain_valid", {31'd0, ld_valid}, 32'd0);
        if (ld_busy) busy_cycles++;
        @(negedge clk);
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      if (ld_busy) busy_cycles++;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("drain_busy_cycles", busy_cycles, 5);
      check("drain_idle", {30'd0, ld_busy, ld_valid}, 32'd0);
    end else if (fmode == 2) begin
      flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd;
      @(negedge clk);
      flush = 1'b0; mem_rvalid = 1'b0;
      check("flush_rvalid_idle", {30'd0, ld_busy, ld_valid}, 32'd0);
    end else begin
      for (int i = 0; i < waits; i++) begin
        check("wait_state", {29'd0, mem_rd_en, ld_valid, ld_busy}, 32'd1);
        check("wait_addr", mem_addr, aligned);
        ld_req = 1'($urandom_range(0, 1));
        addr = $urandom;
        busy_cycles++;
        @(negedge clk);
      end
      ld_req = 1'b0;
      if (ld_busy) busy_cycles++;
      mem_rvalid = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      exp_valid++;
      check("resp_valid", {31'd0, ld_valid}, 32'd1);
      check("resp_data", ld_data, model_data(t, a, rd));
      if (ld_busy) busy_cycles++;
      @(negedge clk);
      check("busy_cycles", busy_cycles, waits + 3);
      check("after_idle", {30'd0, ld_busy, ld_valid}, 32'd0);
    end
    $display("load type=%0d addr=%h rdata=%h waits=%0d fmode=%0d exp=%h got=%h",
             t, a, rd, waits, fmode, model_data(t, a, rd), ld_data);
  endtask

  initial begin
    #1;
    check("reset_outputs", {28'd0, mem_rd_en, ld_busy, ld_valid, ld_misalign}, 32'd0);
    check("reset_data", ld_data, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_load(3'd3, 32'h103, 32'h80123456, 0, 0);
    do_load(3'd2, 32'h202, 32'hBEEF1234, 0, 0);
    do_load(3'd1, 32'h202, 32'hBEEF1234, 0, 0);
    do_load(3'd4, 32'h201, 32'hBEEF1234, 1, 0);
    do_load(3'd0, 32'h300, 32'hBEEF1234, 3, 0);
    do_load(3'd1, 32'h401, 32'hBEEF1234, 0, 0);
    do_load(3'd0, 32'h600, 32'h11223344, 0, 1);
    do_load(3'd0, 32'h604, 32'h55667788, 0, 0);
    do_load(3'd5, 32'h700, 32'hCAFEF00D, 1, 2);

    for (int n = 0; n < 40; n++) begin
      int fm;
      fm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_load(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 3)), fm);
    end

    // Asynchronous reset while waiting for the response.
    @(negedge clk);
    ld_req = 1'b1; ld_type = 3'd0; addr = 32'h500;
    @(negedge clk);
    ld_req = 1'b0; exp_rd++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {28'd0, mem_rd_en, ld_busy, ld_valid, ld_misalign}, 32'd0);
    check("async_reset_addr", mem_addr, 32'd0);
    check("async_reset_data", ld_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stray_rvalid", {30'd0, ld_busy, ld_valid}, 32'd0);
    @(negedge clk);
    $display("reset in WAIT then stray rvalid handled");

    check("valid_pulses", valid_seen, exp_valid);
    check("rd_strobes", rd_seen, exp_rd);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
